// File: rtl/ts_rd_ctrl_if.sv
// ts_rd_ctrl_if
// Groups the signals between one TS read controller and its neighbours.
// The controller uses the slave modport. The environment uses the master
// modport: that is the deinterleaver channel plus the host/demux consumer.
//   ts_int / rd_len     : slot-ready pulse and byte count for that slot
//   ts_en_rd            : one-byte read request toward the deinterleaver
//   ts_en_out / ts_dout : returned byte strobe and data
//   ts_overflow         : deinterleaver overflow level
//   out_*               : valid/ready byte stream with start/end-of-slot marks
//   busy / slot_done    : status of the slot in progress
//   err / err_clr       : sticky error flag and its clear
interface ts_rd_ctrl_if;
  logic        ts_int;
  logic [16:0] rd_len;
  logic        ts_en_rd;
  logic        ts_en_out;
  logic [7:0]  ts_dout;
  logic        ts_overflow;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_ready;
  logic        busy;
  logic        slot_done;
  logic        err;
  logic        err_clr;

  modport slave (
    input  ts_int, rd_len, ts_en_out, ts_dout, ts_overflow, out_ready, err_clr,
    output ts_en_rd, out_valid, out_data, out_sof, out_eof, busy, slot_done, err
  );

  modport master (
    output ts_int, rd_len, ts_en_out, ts_dout, ts_overflow, out_ready, err_clr,
    input  ts_en_rd, out_valid, out_data, out_sof, out_eof, busy, slot_done, err
  );
endinterface

// File: rtl/ts_rd_ctrl.sv
// ts_rd_ctrl
// Read-side controller for one byte-deinterleaver channel.
// On each slot-ready interrupt it issues paced one-byte read requests.
// It buffers the returned bytes in a small show-ahead FIFO and streams
// them out with start/end-of-slot markers.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ts_rd_ctrl_if.slave (deinterleaver side, output stream, status)
// Parameter DEPTH has two roles:
//   - FIFO depth in bytes (power of two, 4..64).
//   - Cap on bytes that have been requested but not yet read out.
module ts_rd_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  ts_rd_ctrl_if.slave     bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [16:0]     len_q, len_d;
  logic [16:0]     req_cnt_q, req_cnt_d;
  logic [16:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic            ovf_q;
  logic            en_rd_q, en_rd_d;
  logic [7:0]      mem_q [DEPTH];

  logic            push, pop, spurious, ovf_rise, err_set, out_valid;
  logic            headroom_ok, slot_done;
  logic [CW:0]     occupancy;

  // A returned byte is only accepted against an outstanding request.
  // A strobe with nothing in flight is flagged as an error and dropped.
  assign out_valid  = (fifo_cnt_q != '0);
  assign push       = bus.ts_en_out && (inflight_q != '0);
  assign spurious   = bus.ts_en_out && (inflight_q == '0);
  assign pop        = out_valid && bus.out_ready;
  assign ovf_rise   = bus.ts_overflow && !ovf_q;
  assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
  assign inflight_d = inflight_q + CW'(en_rd_q) - CW'(push);

  // The request output is registered, so its decision looks at the occupancy
  // as it will be after this edge. That keeps FIFO plus in-flight bytes at or
  // below DEPTH.
  assign occupancy   = {1'b0, fifo_cnt_d} + {1'b0, inflight_d};
  assign headroom_ok = (occupancy < (CW+1)'(DEPTH));

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req_cnt_d = req_cnt_q + {16'd0, en_rd_q};
    out_cnt_d = out_cnt_q + {16'd0, pop && (out_cnt_q < len_q)};
    pend_d    = pend_q;
    en_rd_d   = 1'b0;
    slot_done = 1'b0;
    err_set   = spurious || ovf_rise;

    case (state_q)
      IDLE: begin
        if (bus.ts_int) begin
          len_d     = bus.rd_len;
          req_cnt_d = '0;
          out_cnt_d = '0;
          if (bus.rd_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            en_rd_d = headroom_ok;
          end
        end
      end
      READ: begin
        if (bus.ts_int) begin
          if (pend_q) err_set = 1'b1;
          else        pend_d  = 1'b1;
        end
        if (req_cnt_d == len_q) state_d = DRAIN;
        else                    en_rd_d = headroom_ok;
      end
      DRAIN: begin
        if (bus.ts_int) begin
          if (pend_q) err_set = 1'b1;
          else        pend_d  = 1'b1;
        end
        if ((inflight_d == '0) && (fifo_cnt_d == '0)) state_d = DONE;
      end
      DONE: begin
        slot_done = 1'b1;
        // An interrupt arriving in DONE is treated like a pending one.
        // rd_len is sampled here, not when the pending interrupt arrived.
        if (bus.ts_int && pend_q) err_set = 1'b1;
        if (pend_q || bus.ts_int) begin
          pend_d    = 1'b0;
          len_d     = bus.rd_len;
          req_cnt_d = '0;
          out_cnt_d = '0;
          if (bus.rd_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            en_rd_d = headroom_ok;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = bus.err_clr ? 1'b0 : (err_q || err_set);
  end

  // Control state, counters and FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      req_cnt_q  <= '0;
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      en_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      ovf_q      <= bus.ts_overflow;
      en_rd_q    <= en_rd_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage. It has no reset; out_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.ts_dout;
  end

  assign bus.ts_en_rd  = en_rd_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.out_sof   = out_valid && (out_cnt_q == '0);
  assign bus.out_eof   = out_valid && (out_cnt_q == (len_q - 17'd1));
  assign bus.busy      = (state_q != IDLE);
  assign bus.slot_done = slot_done;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ts_rd_ctrl.sv
// tb_ts_rd_ctrl
// Directed bench for ts_rd_ctrl (DEPTH=16).
// A deinterleaver model answers every ts_en_rd with a byte two cycles later.
// When the model drives a byte, it pushes the expected {sof, eof, data} to a
// scoreboard queue. The output monitor pops the queue on every transfer and
// compares the popped value with the DUT output.
module tb_ts_rd_ctrl;

  localparam int LAT = 2;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    int         due;
    bit         track;
  } ret_t;

  typedef struct {
    int         len;
    logic [7:0] seed;
  } slot_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   compCnt;
  int   errCnt;
  bit   spurPending;
  int   slotIdx;
  int   validCnt;

  ret_t       pipe[$];
  slot_t      slotQ[$];
  logic [9:0] expQ[$];
  int         reqCycs[$];
  int         doneCycs[$];

  ts_rd_ctrl_if bus ();

  ts_rd_ctrl #(.DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and cycle index; the index advances on each rising edge.
  initial begin
    clk = 1'b0;
    cyc = 0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Deinterleaver model: drives the byte due this cycle, then records any new request.
  initial begin
    ret_t r;
    bus.ts_en_out = 1'b0;
    bus.ts_dout   = 8'h00;
    slotIdx       = 0;
    forever begin
      @(negedge clk);
      bus.ts_en_out = 1'b0;
      bus.ts_dout   = 8'h00;
      if (spurPending) begin
        bus.ts_en_out = 1'b1;
        bus.ts_dout   = 8'hEE;
        spurPending   = 1'b0;
      end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
        r = pipe.pop_front();
        bus.ts_en_out = 1'b1;
        bus.ts_dout   = r.data;
        if (r.track) expQ.push_back({r.sof, r.eof, r.data});
      end
      if (bus.ts_en_rd === 1'b1) begin
        reqCycs.push_back(cyc);
        r.due = cyc + LAT;
        if (slotQ.size() > 0) begin
          r.data  = slotQ[0].seed + 8'(slotIdx);
          r.sof   = (slotIdx == 0);
          r.eof   = (slotIdx == slotQ[0].len - 1);
          r.track = 1'b1;
          slotIdx++;
          if (slotIdx == slotQ[0].len) begin
            void'(slotQ.pop_front());
            slotIdx = 0;
          end
        end else begin
          r.data  = 8'hFF;
          r.sof   = 1'b0;
          r.eof   = 1'b0;
          r.track = 1'b0;
        end
        pipe.push_back(r);
      end
      if (bus.slot_done === 1'b1) doneCycs.push_back(cyc);
    end
  end

  // Output monitor; samples shortly after the falling edge, once inputs have settled.
  initial begin
    logic [9:0] e;
    validCnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid === 1'b1) validCnt++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected", {22'd0, bus.out_sof, bus.out_eof, bus.out_data}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_byte", {22'd0, bus.out_sof, bus.out_eof, bus.out_data}, {22'd0, e});
        end
      end
    end
  end

  // Pulses ts_int for one cycle with the given length. t is the cycle of the pulse.
  task automatic applyStimulus(input logic [16:0] len, input logic [7:0] seed, input bit track, output int t);
    slot_t s;
    @(negedge clk);
    bus.ts_int = 1'b1;
    bus.rd_len = len;
    t = cyc;
    if (track && len != 0) begin
      s.len  = int'(len);
      s.seed = seed;
      slotQ.push_back(s);
    end
    @(negedge clk);
    bus.ts_int = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (bus.busy !== 1'b0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic clearStats();
    reqCycs.delete();
    doneCycs.delete();
    validCnt = 0;
  endtask

  task automatic pulseErrClr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int t, t2, firstB;
    compCnt      = 0;
    errCnt       = 0;
    spurPending  = 1'b0;
    reset_n      = 1'b0;
    bus.ts_int      = 1'b0;
    bus.rd_len      = '0;
    bus.ts_overflow = 1'b0;
    bus.out_ready   = 1'b1;
    bus.err_clr     = 1'b0;

    // Reset values
    waitCycles(2);
    checkOutput("reset_outputs",
      {20'd0, bus.ts_en_rd, bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.slot_done, bus.err, bus.out_data, 1'b0},
      32'd0);
    reset_n = 1'b1;
    waitCycles(2);

    // Five-byte slot, consumer always ready
    $display("[TB] slot of 5 bytes");
    clearStats();
    applyStimulus(17'd5, 8'h10, 1'b1, t);
    checkOutput("start_busy_req", {30'd0, bus.busy, bus.ts_en_rd}, 32'd3);
    waitIdle(100);
    checkOutput("len5_req_count", reqCycs.size(), 5);
    checkOutput("len5_first_req", reqCycs[0], t + 1);
    checkOutput("len5_last_req", reqCycs[4], t + 5);
    checkOutput("len5_done_count", doneCycs.size(), 1);
    checkOutput("len5_done_cycle", doneCycs[0], t + 5 + LAT + 2);
    checkOutput("len5_sb_empty", expQ.size(), 0);
    checkOutput("len5_err", {31'd0, bus.err}, 32'd0);

    // Forty-byte slot with a stalled consumer: throttle at DEPTH
    $display("[TB] slot of 40 bytes, consumer stalled");
    clearStats();
    bus.out_ready = 1'b0;
    applyStimulus(17'd40, 8'h40, 1'b1, t);
    waitCycles(39);
    checkOutput("stall_req_count", reqCycs.size(), 16);
    checkOutput("stall_no_req", {31'd0, bus.ts_en_rd}, 32'd0);
    checkOutput("stall_head", {22'd0, bus.out_valid, bus.out_sof, bus.out_data}, {22'd0, 1'b1, 1'b1, 8'h40});
    bus.out_ready = 1'b1;
    waitIdle(300);
    checkOutput("len40_req_count", reqCycs.size(), 40);
    checkOutput("len40_done_count", doneCycs.size(), 1);
    checkOutput("len40_sb_empty", expQ.size(), 0);
    checkOutput("len40_err", {31'd0, bus.err}, 32'd0);

    // Pending interrupt mid-slot; rd_len is sampled at DONE. A third interrupt overflows the pending slot.
    $display("[TB] pending interrupt");
    clearStats();
    applyStimulus(17'd6, 8'h80, 1'b1, t);
    applyStimulus(17'd9, 8'h00, 1'b0, t2);
    bus.rd_len = 17'd3;
    slotQ.push_back('{len: 3, seed: 8'hC0});
    applyStimulus(17'd3, 8'h00, 1'b0, t2);
    checkOutput("pend_overflow_err", {31'd0, bus.err}, 32'd1);
    pulseErrClr();
    checkOutput("err_clr", {31'd0, bus.err}, 32'd0);
    waitIdle(200);
    checkOutput("pend_done_count", doneCycs.size(), 2);
    checkOutput("pend_req_count", reqCycs.size(), 9);
    firstB = -1;
    foreach (reqCycs[i]) if (firstB < 0 && reqCycs[i] > doneCycs[0]) firstB = reqCycs[i];
    checkOutput("pend_restart", firstB, doneCycs[0] + 1);
    checkOutput("pend_sb_empty", expQ.size(), 0);
    checkOutput("pend_err", {31'd0, bus.err}, 32'd0);

    // Zero-length slot
    $display("[TB] zero-length slot");
    clearStats();
    applyStimulus(17'd0, 8'h00, 1'b1, t);
    waitCycles(4);
    checkOutput("len0_req_count", reqCycs.size(), 0);
    checkOutput("len0_done_count", doneCycs.size(), 1);
    checkOutput("len0_no_valid", validCnt, 0);
    checkOutput("len0_idle", {31'd0, bus.busy}, 32'd0);

    // Spurious returned byte in IDLE
    $display("[TB] spurious byte and overflow edge");
    clearStats();
    @(posedge clk);
    #1 spurPending = 1'b1;
    waitCycles(2);
    checkOutput("spurious_err", {31'd0, bus.err}, 32'd1);
    checkOutput("spurious_no_valid", validCnt, 0);
    pulseErrClr();
    checkOutput("spurious_clr", {31'd0, bus.err}, 32'd0);

    // Overflow: only the rising edge sets err, not the held level
    bus.ts_overflow = 1'b1;
    waitCycles(2);
    checkOutput("ovf_err", {31'd0, bus.err}, 32'd1);
    pulseErrClr();
    waitCycles(2);
    checkOutput("ovf_level_no_err", {31'd0, bus.err}, 32'd0);
    bus.ts_overflow = 1'b0;
    checkOutput("ovf_no_valid", validCnt, 0);

    // Reset in mid-slot with bytes buffered
    $display("[TB] reset mid-slot");
    clearStats();
    bus.out_ready = 1'b0;
    applyStimulus(17'd40, 8'h20, 1'b1, t);
    waitCycles(9);
    checkOutput("prereset_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
      {20'd0, bus.ts_en_rd, bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.slot_done, bus.err, bus.out_data, 1'b0},
      32'd0);
    expQ.delete();
    slotQ.delete();
    slotIdx = 0;
    foreach (pipe[i]) pipe[i].track = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    waitCycles(4);
    checkOutput("late_return_err", {31'd0, bus.err}, 32'd1);
    pulseErrClr();
    checkOutput("late_return_clr", {31'd0, bus.err}, 32'd0);
    bus.out_ready = 1'b1;
    clearStats();
    applyStimulus(17'd7, 8'h60, 1'b1, t);
    waitIdle(100);
    checkOutput("post_reset_req_count", reqCycs.size(), 7);
    checkOutput("post_reset_done_count", doneCycs.size(), 1);
    checkOutput("post_reset_sb_empty", expQ.size(), 0);
    checkOutput("post_reset_err", {31'd0, bus.err}, 32'd0);

    waitCycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule
